// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start bit, SIZE data bits MSB first, optional even-parity bit.
// Define DESERIALIZER_PARITY_EN to add the parity bit and the PARITY state.
module deserializer #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            serial_in,
    input  logic            read_enable,
    output logic [SIZE-1:0] data_out,
    output logic            valid,
    output logic            busy,
    output logic            overrun,
    output logic            parity_error
);
    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

`ifdef DESERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] shreg;
    logic [SIZE-1:0] shreg_next;

    assign shreg_next = {shreg[SIZE-2:0], serial_in};

`ifdef DESERIALIZER_PARITY_EN
    logic perr;
    assign parity_error = perr;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            // An acknowledge clears valid unless a word completes on this same edge.
            if (read_enable && valid)
                valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef DESERIALIZER_PARITY_EN
                        state <= PARITY;
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
                        data_out <= shreg_next;
                        valid    <= 1'b1;
                        overrun  <= valid && !read_enable;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef DESERIALIZER_PARITY_EN
                PARITY: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    data_out <= shreg;
                    perr     <= (^shreg) ^ serial_in;
                    valid    <= 1'b1;
                    overrun  <= valid && !read_enable;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (SIZE=8); adapts to DESERIALIZER_PARITY_EN when defined.
module tb_deserializer;
    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            serial_in;
    logic            read_enable;
    logic [SIZE-1:0] data_out;
    logic            valid;
    logic            busy;
    logic            overrun;
    logic            parity_error;

    int checks   = 0;
    int failures = 0;
    logic [SIZE-1:0] exp_q[$];
    bit model_valid = 1'b0;
    logic [SIZE-1:0] model_data = '0;

    deserializer #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .read_enable(read_enable),
        .data_out(data_out), .valid(valid), .busy(busy), .overrun(overrun),
        .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the completion edge.
    task automatic send_frame(input logic [SIZE-1:0] w, input logic par,
                              input bit ack_start, input bit ack_last);
        logic [SIZE-1:0] exp_w;
        bit   exp_ovr;
        logic exp_perr;
        exp_q.push_back(w);
        serial_in   = 1'b1;
        read_enable = ack_start;
        if (ack_start) model_valid = 1'b0;
        @(negedge clk);
        read_enable = 1'b0;
        check_val("busy_after_start", busy, 1);
        for (int i = SIZE - 1; i >= 0; i--) begin
            serial_in = w[i];
`ifndef DESERIALIZER_PARITY_EN
            if (i == 0) read_enable = ack_last;
`endif
            @(negedge clk);
        end
`ifdef DESERIALIZER_PARITY_EN
        check_val("valid_before_parity_edge", valid, model_valid);
        serial_in   = par;
        read_enable = ack_last;
        @(negedge clk);
        exp_perr = (^w) ^ par;
`else
        exp_perr = 1'b0;
`endif
        read_enable = 1'b0;
        serial_in   = 1'b0;
        exp_ovr     = model_valid && !ack_last;
        model_valid = 1'b1;
        model_data  = w;
        check_val("valid_on_completion", valid, 1);
        if (valid) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty got=%0h exp=none", data_out);
            end else begin
                exp_w = exp_q.pop_front();
                check_val("data_out", data_out, exp_w);
            end
        end
        check_val("overrun", overrun, exp_ovr);
        check_val("busy_after_done", busy, 0);
        check_val("parity_error", parity_error, exp_perr);
    endtask

    task automatic idle_cycles(input int n);
        serial_in = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic ack_pulse();
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        model_valid = 1'b0;
        check_val("valid_after_ack", valid, 0);
        check_val("data_stable_after_ack", data_out, model_data);
    endtask

    initial begin
        logic [SIZE-1:0] rw;
        bit ra;
        reset = 1'b1; serial_in = 1'b0; read_enable = 1'b0;
        @(negedge clk); @(negedge clk);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_parity_error", parity_error, 0);
        reset = 1'b0;

        idle_cycles(3);
        check_val("idle_busy", busy, 0);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        check_val("ack_without_valid", valid, 0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        check_val("overrun_one_cycle_a5", overrun, 0);
        ack_pulse();

        // Back-to-back with acknowledge during the next frame's start bit.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        ack_pulse();

        // Unread word overwritten.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        check_val("overrun_pulse_width", overrun, 0);
        check_val("valid_held", valid, 1);
        read_enable = 1'b1; @(negedge clk); read_enable = 1'b0; model_valid = 1'b0;

        // Acknowledge on the completion edge itself.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        ack_pulse();

        // Reset in the middle of a frame.
        serial_in = 1'b1; @(negedge clk);
        serial_in = 1'b0; @(negedge clk);
        serial_in = 1'b1; @(negedge clk);
        serial_in = 1'b0; @(negedge clk);
        serial_in = 1'b1; @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("midrst_data_out", data_out, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_valid", valid, 0);
        @(negedge clk);
        reset = 1'b0;
        model_valid = 1'b0;
        model_data  = '0;
        idle_cycles(2);
        check_val("post_rst_idle", busy, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        ack_pulse();

        // Parity cases (parity bit ignored when the option is off).
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        ack_pulse();
        send_frame(8'h07, 1'b0, 1'b0, 1'b0);
        ack_pulse();

        // Random frames with random acknowledges and gaps.
        for (int k = 0; k < 6; k++) begin
            rw = SIZE'($urandom);
            ra = bit'($urandom_range(0, 1));
            send_frame(rw, 1'(^rw), 1'b0, ra);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning data word width in bits (SIZE >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port serial_in  input  1  serial line; idles low; one bit sampled per clk edge.
REQ-005 SHALL have port read_enable  input  1  consumer acknowledge of the current word.
REQ-006 SHALL have port data_out  output  SIZE  last fully received word.
REQ-007 SHALL have port valid  output  1  data_out holds an unacknowledged word.
REQ-008 SHALL have port busy  output  1  frame reception in progress (state != IDLE).
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: unread word overwritten.
REQ-010 SHALL have port parity_error  output  1  parity status of the word in data_out.

Function
REQ-011 Frame format SHALL be one start bit (1), then SIZE data bits MSB first, then (with the parity option only) one parity bit.
REQ-012 State machine SHALL have states IDLE, SHIFT, and PARITY (PARITY present only with the parity option).
REQ-013 In IDLE, serial_in=1 at an edge SHALL move to SHIFT with bit counter cleared; serial_in=0 SHALL leave the block in IDLE.
REQ-014 In SHIFT, each edge SHALL shift serial_in into the shift register LSB and increment the counter.
REQ-015 The edge that samples data bit SIZE-1 SHALL go to IDLE (or PARITY if enabled); the counter SHALL never exceed SIZE-1.
REQ-016 On word completion, data_out SHALL load the assembled word and valid SHALL be 1 after that same edge.
REQ-017 Latency: with the start bit sampled at edge 0, valid SHALL be high after edge SIZE (edge SIZE+1 with parity).
REQ-018 Back-to-back frames SHALL be accepted: a start bit sampled on the first IDLE edge after completion SHALL start a new frame.
REQ-019 While busy, serial_in=1 SHALL be treated as data, never as a start bit.
REQ-020 read_enable with valid=1 SHALL clear valid at the next edge; read_enable with valid=0 SHALL be ignored.
REQ-021 Completion with valid=1 and read_enable=1 on the same edge SHALL load the new word, keep valid=1, and not assert overrun.
REQ-022 Completion with valid=1 and read_enable=0 SHALL overwrite data_out, keep valid=1, and pulse overrun high for exactly one cycle.
REQ-023 data_out SHALL remain stable between completions, regardless of read_enable.
REQ-024 busy SHALL be 1 in SHIFT and PARITY and 0 in IDLE.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, counter 0, shift register 0, data_out 0, valid 0, busy 0, overrun 0, parity_error 0.
REQ-026 Reset mid-frame SHALL discard the partial word; after release, the block SHALL wait for a new start bit.
REQ-027 Reset SHALL take priority over every other event, including word completion on the same edge.

Configuration
REQ-028 Macro DESERIALIZER_PARITY_EN defined: frame SHALL include an even-parity bit sampled in PARITY.
REQ-029 With the macro, word completion SHALL occur on the parity-bit edge, and parity_error SHALL load (XOR of data bits) XOR (parity bit), updated only on completion.
REQ-030 Macro undefined: no PARITY state, frame is 1+SIZE bits, and parity_error SHALL be constant 0.

Verification
REQ-031 SIZE=8, no parity: start bit then 8'hA5 MSB first -> valid=1 after edge 8, data_out=8'hA5, busy low from then.
REQ-032 SIZE=8: frames 8'h3C and 8'hFF back-to-back, read_enable pulsed after each -> two words delivered in order, overrun stays 0.
REQ-033 SIZE=8: second frame 8'h81 completes while 8'h3C unread -> data_out=8'h81, valid=1, overrun high exactly one cycle.
REQ-034 SIZE=8: read_enable asserted on the completion edge of 8'h81 while 8'h3C valid -> data_out=8'h81, valid=1, overrun=0.
REQ-035 SIZE=8: reset asserted after 4 data bits, then frame 8'h5A -> outputs 0 during reset; data_out=8'h5A afterwards with no residue.
REQ-036 SIZE=8, DESERIALIZER_PARITY_EN: 8'h07 with parity 1 -> parity_error=0; with parity 0 -> parity_error=1; valid after edge 9.
